// File: rtl/scan_select_pkg.sv
// scan_select_pkg: shared types and constants for the scan_select slice.
// Holds the FSM state encoding, the index and request widths, and the
// pointer-advance helper used when a grant ends.
package scan_select_pkg;

  localparam int IDX_W   = 2;
  localparam int NUM_REQ = 4;

  // The ST_ prefix keeps the GUARD state name clear of the GUARD parameter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // Next search start after a grant: the index just served plus one,
  // wrapping 3 -> 0 through the natural 2-bit overflow.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/scan_select_if.sv
// scan_select_if: request/select bundle between the requesters and the
// select generator. The master side drives req; the slave side (scan_select)
// returns the decoder select pair a/b, the enable en, busy and tout.
interface scan_select_if;
  import scan_select_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               a;
  logic               b;
  logic               en;
  logic               busy;
  logic               tout;

  modport master (
    output req,
    input  a, b, en, busy, tout
  );

  modport slave (
    input  req,
    output a, b, en, busy, tout
  );

endinterface

// File: rtl/scan_select_rr_pick.sv
// rr_pick: combinational rotated-priority search. Looks at req starting at
// ptr and walking upward mod NUM_REQ; the first set bit wins. any flags that
// at least one request is present.
module rr_pick
  import scan_select_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + k[IDX_W-1:0];
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_select.sv
// scan_select: round-robin select source for the 2-to-4 decoder stage.
// Grants one of four level-sensitive requests, presents the winner as
// {a,b} with en high while the grant is held, and forces GUARD idle cycles
// with en low after each grant so decoder outputs never overlap.
// Optional feature macro: SCAN_SELECT_TIMEOUT_EN caps each grant at MAX_HOLD
// cycles and pulses tout when a grant is cut off.
module scan_select
  import scan_select_pkg::*;
#(
  parameter int GUARD    = 1,
  parameter int MAX_HOLD = 16
)(
  input  logic         clk,
  input  logic         rst_n,
  scan_select_if.slave bus
);

  localparam logic [3:0] GUARD_M1 = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;

  // Parameter legality is checked once at elaboration.
  if (GUARD < 0 || GUARD > 15) begin : g_bad_guard
    $error("scan_select: GUARD must be in 0..15");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("scan_select: MAX_HOLD must be in 1..255");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ab_q, ab_d;
  logic             en_q, en_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             busy_q;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             cur_req;
  logic             cut_off;

`ifdef SCAN_SELECT_TIMEOUT_EN
  localparam logic [7:0] MAX_HOLD_M1 = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       tout_q, tout_d;
`endif

  rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The request of the index currently held; its drop ends the grant.
  assign cur_req = bus.req[ab_q];

`ifdef SCAN_SELECT_TIMEOUT_EN
  // hold_q counts completed GRANT cycles, so MAX_HOLD-1 marks the last one.
  assign cut_off = (hold_q == MAX_HOLD_M1);
`else
  assign cut_off = 1'b0;
`endif

  // Next-state and next-output decision; everything holds unless changed.
  always_comb begin
    state_d = state_q;
    ab_d    = ab_q;
    en_d    = en_q;
    ptr_d   = ptr_q;
    gcnt_d  = gcnt_q;
`ifdef SCAN_SELECT_TIMEOUT_EN
    hold_d  = hold_q;
    tout_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          ab_d    = pick_idx;
          en_d    = 1'b1;
`ifdef SCAN_SELECT_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!cur_req || cut_off) begin
          // Release and timeout end identically; {a,b} stays frozen.
          en_d  = 1'b0;
          ptr_d = idx_next(ab_q);
`ifdef SCAN_SELECT_TIMEOUT_EN
          tout_d = cur_req;
`endif
          if (GUARD > 0) begin
            state_d = ST_GUARD;
            gcnt_d  = GUARD_M1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
`ifdef SCAN_SELECT_TIMEOUT_EN
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      ST_GUARD: begin
        if (gcnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // State, counters and output registers; reset wins from any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ab_q    <= '0;
      en_q    <= 1'b0;
      ptr_q   <= '0;
      gcnt_q  <= '0;
      busy_q  <= 1'b0;
`ifdef SCAN_SELECT_TIMEOUT_EN
      hold_q  <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      en_q    <= en_d;
      ptr_q   <= ptr_d;
      gcnt_q  <= gcnt_d;
      busy_q  <= (state_d != ST_IDLE);
`ifdef SCAN_SELECT_TIMEOUT_EN
      hold_q  <= hold_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign bus.a    = ab_q[1];
  assign bus.b    = ab_q[0];
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
`ifdef SCAN_SELECT_TIMEOUT_EN
  assign bus.tout = tout_q;
`else
  assign bus.tout = 1'b0;
`endif

endmodule

// File: tb/tb_scan_select.sv
// tb_scan_select: scenario bench for scan_select. dut runs GUARD=1,
// MAX_HOLD=4; dut0 runs GUARD=0. Expected grant indices are queued when a
// request pattern is driven and popped when the grant appears.
module tb_scan_select;
  import scan_select_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  scan_select_if bus1();
  scan_select_if bus0();

  scan_select #(.GUARD(1), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  scan_select #(.GUARD(0), .MAX_HOLD(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.req = 4'b0000;
    bus0.req = 4'b0000;
    tick();
    tick();
    checks++;
    if ({bus1.a, bus1.b, bus1.en, bus1.busy, bus1.tout} !== 5'b0)
      $display("FAIL reset_outs: got %b expected 00000",
               {bus1.a, bus1.b, bus1.en, bus1.busy, bus1.tout});
    if ({bus1.a, bus1.b, bus1.en, bus1.busy, bus1.tout} !== 5'b0) errors++;
    checks++;
    if ({bus0.a, bus0.b, bus0.en, bus0.busy, bus0.tout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs0: got %b expected 00000",
               {bus0.a, bus0.b, bus0.en, bus0.busy, bus0.tout});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int e;
    bus1.req = 4'b0100;
    exp_q.push_back(2);
    tick();
    checks++;
    if (bus1.en !== 1'b1) begin
      errors++;
      $display("FAIL single_en: got %b expected 1", bus1.en);
    end
    e = exp_q.pop_front();
    checks++;
    if ({bus1.a, bus1.b} !== e[1:0]) begin
      errors++;
      $display("FAIL single_idx: got %b expected %b", {bus1.a, bus1.b}, e[1:0]);
    end
    repeat (3) tick();
    checks++;
    if ({bus1.a, bus1.b, bus1.en} !== 3'b101) begin
      errors++;
      $display("FAIL single_hold: got %b expected 101", {bus1.a, bus1.b, bus1.en});
    end
    bus1.req = 4'b0000;
    tick();
    checks++;
    if ({bus1.a, bus1.b, bus1.en, bus1.busy} !== 4'b1001) begin
      errors++;
      $display("FAIL single_release: got %b expected 1001",
               {bus1.a, bus1.b, bus1.en, bus1.busy});
    end
    tick();
    checks++;
    if (bus1.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_guard_end: busy got %b expected 0", bus1.busy);
    end
  endtask

  // ptr is 3 after granting index 2: 0011 must pick 0, not 1.
  task automatic test_wrap_skip();
    int e;
    int n;
    bus1.req = 4'b0011;
    exp_q.push_back(0);
    n = 0;
    while (bus1.en !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (bus1.en !== 1'b1) begin
      errors++;
      $display("FAIL wrap_wait: en got %b expected 1 within 10 cycles", bus1.en);
    end
    e = exp_q.pop_front();
    checks++;
    if ({bus1.a, bus1.b} !== e[1:0]) begin
      errors++;
      $display("FAIL wrap_idx: got %b expected %b", {bus1.a, bus1.b}, e[1:0]);
    end
    bus1.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_fairness();
    int e;
    int n;
    logic [3:0] r;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    r = 4'b1111;
    bus1.req = r;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (bus1.en !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (bus1.en !== 1'b1) begin
        errors++;
        $display("FAIL rr_wait[%0d]: en got %b expected 1 within 10 cycles", i, bus1.en);
      end
      e = exp_q.pop_front();
      checks++;
      if ({bus1.a, bus1.b} !== e[1:0]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %b expected %b", i, {bus1.a, bus1.b}, e[1:0]);
      end
      if (i > 0) begin
        checks++;
        if (n < 2) begin
          errors++;
          $display("FAIL rr_gap[%0d]: en low cycles got %0d expected >= 2", i, n);
        end
      end
      r[e[1:0]] = 1'b0;
      bus1.req = r;
      tick();
      r[e[1:0]] = 1'b1;
      bus1.req = r;
    end
    bus1.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    int e;
    bus1.req = 4'b1000;
    tick();
    checks++;
    if ({bus1.a, bus1.b, bus1.en} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_pre: got %b expected 111", {bus1.a, bus1.b, bus1.en});
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus1.a, bus1.b, bus1.en, bus1.busy, bus1.tout} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outs: got %b expected 00000",
               {bus1.a, bus1.b, bus1.en, bus1.busy, bus1.tout});
    end
    rst_n = 1'b1;
    exp_q.push_back(3);
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({bus1.a, bus1.b, bus1.en} !== {e[1:0], 1'b1}) begin
      errors++;
      $display("FAIL midrst_regrant: got %b expected %b",
               {bus1.a, bus1.b, bus1.en}, {e[1:0], 1'b1});
    end
    bus1.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_guard0();
    int e;
    bus0.req = 4'b0001;
    exp_q.push_back(0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({bus0.a, bus0.b, bus0.en} !== {e[1:0], 1'b1}) begin
      errors++;
      $display("FAIL g0_first: got %b expected %b", {bus0.a, bus0.b, bus0.en}, {e[1:0], 1'b1});
    end
    tick();
    bus0.req = 4'b0010;
    exp_q.push_back(1);
    tick();
    checks++;
    if ({bus0.en, bus0.busy} !== 2'b00) begin
      errors++;
      $display("FAIL g0_gap: en/busy got %b expected 00", {bus0.en, bus0.busy});
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({bus0.a, bus0.b, bus0.en} !== {e[1:0], 1'b1}) begin
      errors++;
      $display("FAIL g0_second: got %b expected %b", {bus0.a, bus0.b, bus0.en}, {e[1:0], 1'b1});
    end
    bus0.req = 4'b0000;
    tick();
  endtask

`ifdef SCAN_SELECT_TIMEOUT_EN
  task automatic test_timeout();
    int e;
    int bad;
    bus1.req = 4'b0001;
    exp_q.push_back(0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({bus1.a, bus1.b, bus1.en} !== {e[1:0], 1'b1}) begin
      errors++;
      $display("FAIL to_grant: got %b expected %b", {bus1.a, bus1.b, bus1.en}, {e[1:0], 1'b1});
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus1.en !== 1'b1 || bus1.tout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_hold: bad cycles got %0d expected 0", bad);
    end
    tick();
    checks++;
    if ({bus1.en, bus1.tout} !== 2'b01) begin
      errors++;
      $display("FAIL to_cut: en/tout got %b expected 01", {bus1.en, bus1.tout});
    end
    tick();
    checks++;
    if ({bus1.en, bus1.tout} !== 2'b00) begin
      errors++;
      $display("FAIL to_pulse: en/tout got %b expected 00", {bus1.en, bus1.tout});
    end
    exp_q.push_back(0);
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({bus1.a, bus1.b, bus1.en} !== {e[1:0], 1'b1}) begin
      errors++;
      $display("FAIL to_regrant: got %b expected %b", {bus1.a, bus1.b, bus1.en}, {e[1:0], 1'b1});
    end
    bus1.req = 4'b0000;
    tick();
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    bus1.req = 4'b0001;
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus1.en !== 1'b1 || bus1.tout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_timeout: bad cycles got %0d expected 0", bad);
    end
    bus1.req = 4'b0000;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wrap_skip();
    test_fairness();
    test_reset_mid_grant();
    test_guard0();
`ifdef SCAN_SELECT_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_select.md
# scan_select

Sequential source of the 2-bit select pair and enable that drive the 2-to-4 decoder stage. It arbitrates four request lines round-robin and presents the winning index as `a` (MSB) and `b` (LSB), with `en` asserted while the grant is held. A configurable guard gap forces `en` low between consecutive grants, so the decoder's one-hot outputs never overlap or glitch. `a`, `b` and `en` connect directly to the decoder's inputs of the same names.

## Interface
- `GUARD`, default 1: idle cycles with `en`=0 after each grant ends; legal range 0..15.
- `MAX_HOLD`, default 16: maximum grant length in cycles; legal range 1..255; used only with `SCAN_SELECT_TIMEOUT_EN`.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `req`  in  4: request lines, level-sensitive; `req[i]` asks for decoder output `y[i]`.
- `a`  out  1: grant index MSB, registered.
- `b`  out  1: grant index LSB, registered.
- `en`  out  1: grant valid, registered; drives the decoder enable.
- `busy`  out  1: high when in GRANT or GUARD state.
- `tout`  out  1: one-cycle pulse when a grant is cut off by timeout; constant 0 when the timeout feature is compiled out.

## Operation
- **States:**
  - IDLE: `en`=0.
  - GRANT: `en`=1.
  - GUARD: `en`=0; counts `GUARD` cycles.
- **Rotating pointer:** `ptr`, 2 bits, reset value 0.
  - Arbitration searches `req` in the order `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
  - The first index with its request set wins.
- **IDLE → GRANT:** taken when `req` is non-zero. The winning index is registered into `{a,b}` and `en` goes to 1.
- **GRANT:**
  - `{a,b}` is frozen for the whole grant.
  - Other requests are ignored until the grant ends.
- **Grant end:** occurs when `req[{a,b}]` is sampled 0.
  - `en` goes to 0 on the same edge.
  - `ptr` is loaded with `{a,b}+1` mod 4; index 3 wraps to 0.
  - Next state is GUARD if `GUARD`>0, otherwise IDLE.
- **GUARD:** the counter loads `GUARD-1` on entry and decrements each cycle; at 0 the next state is IDLE. Requests are not sampled in GUARD.
- **`{a,b}` while `en`=0:** holds the last granted index, so the pair never toggles while enable is low. After reset it holds 00.
- **`GUARD`=0:** grant end goes straight to IDLE. A new grant is then possible on the next edge, giving a single `en`=0 cycle between grants.
- **Reset:** `rst_n` low at an edge forces the following, regardless of state, including mid-grant and mid-guard:
  - state IDLE
  - `a`=0, `b`=0, `en`=0
  - `busy`=0, `tout`=0
  - `ptr`=0, guard counter 0, hold counter 0
- **Withdrawn request:** a request that drops before it is granted is simply not selected. There is no latching of requests.

## Timing
- **Grant latency:** `req` non-zero and sampled in IDLE at edge N gives `en`=1 and a valid `{a,b}` after edge N. Latency is 1 cycle.
- **Release latency:** `req[{a,b}]` sampled 0 at edge K gives `en`=0 after edge K.
- **Gap between grants:** `en` stays low for at least `GUARD`+1 cycles.
  - Edge K ends the grant.
  - `GUARD` cycles are spent in GUARD.
  - One IDLE evaluation edge follows.
- **`busy`:** registered; equals (state != IDLE) after each edge.
- **Output timing:** all outputs change only on `clk` rising edges and are glitch-free into the decoder.

## Configuration
- **Macro:** `SCAN_SELECT_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches `MAX_HOLD` with `req[{a,b}]` still 1, the grant ends exactly as a normal release (`en`=0, `ptr` advance, GUARD/IDLE) and `tout`=1 for that one cycle.
  - A requester that stays asserted re-competes normally afterwards.
- **Not defined:**
  - A grant lasts until its request drops, with no upper bound.
  - `tout` is tied to 0.
  - No hold-counter logic exists.

## Structure
- **Shared package `scan_select_pkg`:**
  - state enum (IDLE, GRANT, GUARD)
  - index width constant `IDX_W`=2
  - `NUM_REQ`=4
- **One sub-module, `rr_pick`:** purely combinational; inputs are `req[3:0]` and `ptr[1:0]`; outputs are `idx[1:0]` and `any`. It implements the rotated priority search.
- **Top level:** FSM, counters and output registers.

## Test plan
- **Single request:** reset, then `req`=0100 at edge 1. Expect `{a,b}`=10 and `en`=1 after edge 1. Drop `req` at edge 5: `en`=0 after edge 5, `busy`=1 for one GUARD cycle, `ptr`=3.
- **Round-robin fairness:** `req`=1111 held, each grant released by pulsing its bit low for one cycle. Expect grant order 0,1,2,3,0 and `en`=0 for at least 2 cycles between grants with `GUARD`=1.
- **Wrap and skip:** `ptr`=3 after granting 2, then `req`=0011. Expect index 0 granted, not 1.
- **Reset mid-grant:** `rst_n`=0 for one edge during GRANT with `{a,b}`=11. Expect `a`=`b`=`en`=`busy`=0 after that edge. The next `req`=1000 grants index 3, searched from `ptr`=0.
- **`GUARD`=0:** back-to-back requests 0001 then 0010. Expect exactly one `en`=0 cycle between the two grants.
- **Timeout (macro defined, `MAX_HOLD`=4):** `req`=0001 held constantly. Expect `en` high for 4 cycles, then `tout`=1 for one cycle with `en`=0. Index 0 is re-granted after the guard, since it is the only requester.
